// File: rtl/cc_pkg.sv
// rtl/cc_pkg.sv - shared types and constants for the cache-to-memory arbiter
package cc_pkg;

  // Arbiter phases: sample requests, wait for first beat, collect beats, release
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  // One 128-bit line is four 32-bit beats
  localparam int CC_BURST_LEN = 4;

  // Port indices: data cache on port 0, instruction cache on port 1
  localparam logic CC_PORT_D = 1'b0;
  localparam logic CC_PORT_I = 1'b1;

endpackage

// File: rtl/cc_mem_arbiter_if.sv
// rtl/cc_mem_arbiter_if.sv - cache-side and memory-side refill signals of the arbiter
interface cc_mem_arbiter_if #(
  parameter int ADR_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
);

  // Port 0 (D-cache) refill channel
  logic                  req0_cc2arb;
  logic [ADR_WIDTH-1:0]  adr0_cc2arb;
  logic                  ack_arb2cc0;
  logic [DATA_WIDTH-1:0] dat_arb2cc0;

  // Port 1 (I-cache) refill channel
  logic                  req1_cc2arb;
  logic [ADR_WIDTH-1:0]  adr1_cc2arb;
  logic                  ack_arb2cc1;
  logic [DATA_WIDTH-1:0] dat_arb2cc1;

  // Shared memory refill port
  logic                  req_arb2mem;
  logic [ADR_WIDTH-1:0]  adr_arb2mem;
  logic                  ack_mem2arb;
  logic [DATA_WIDTH-1:0] dat_mem2arb;

  // Arbiter view
  modport slave (
    input  req0_cc2arb, adr0_cc2arb, req1_cc2arb, adr1_cc2arb,
    input  ack_mem2arb, dat_mem2arb,
    output ack_arb2cc0, dat_arb2cc0, ack_arb2cc1, dat_arb2cc1,
    output req_arb2mem, adr_arb2mem
  );

  // Environment view: cache controllers plus memory
  modport master (
    output req0_cc2arb, adr0_cc2arb, req1_cc2arb, adr1_cc2arb,
    output ack_mem2arb, dat_mem2arb,
    input  ack_arb2cc0, dat_arb2cc0, ack_arb2cc1, dat_arb2cc1,
    input  req_arb2mem, adr_arb2mem
  );

endinterface

// File: rtl/cc_mem_arbiter_burst_counter.sv
// rtl/cc_mem_arbiter_burst_counter.sv - beat counter for one line refill
module burst_counter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic done
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_sum;

  // Count after this cycle's beat; done flags the beat that completes the line
  always_comb begin
    count_sum = count + CNT_W'(inc);
    done      = (count_sum == CNT_W'(BURST_LEN));
  end

  // Beat count register: cleared while idle, holds through beat gaps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count_sum;
    end
  end

endmodule

// File: rtl/cc_mem_arbiter.sv
// rtl/cc_mem_arbiter.sv - round-robin refill arbiter between D-cache and I-cache
module cc_mem_arbiter
  import cc_pkg::*;
#(
  parameter int ADR_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = CC_BURST_LEN
) (
  input  logic                clk,
  input  logic                rst,
  cc_mem_arbiter_if.slave     bus,
  output logic [1:0]          grant,
  output logic                busy
);

  arb_state_t           state, state_nxt;
  logic                 rr, rr_nxt;
  logic [1:0]           grant_nxt;
  logic [ADR_WIDTH-1:0] adr_q, adr_nxt;
  logic                 req_q, req_nxt;
  logic                 winner;
  logic                 in_burst;
  logic                 cnt_clr, cnt_inc, cnt_done;

  burst_counter #(
    .BURST_LEN (BURST_LEN)
  ) u_burst_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .done (cnt_done)
  );

  // Winner pick: rr breaks ties, a lone requester always wins
  always_comb begin
    winner = CC_PORT_D;
    if (bus.req0_cc2arb && bus.req1_cc2arb) begin
      winner = rr;
    end else if (bus.req1_cc2arb) begin
      winner = CC_PORT_I;
    end
  end

  // Next-state logic; grant and address are only loaded on leaving IDLE
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    grant_nxt = grant;
    adr_nxt   = adr_q;
    req_nxt   = req_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (bus.req0_cc2arb || bus.req1_cc2arb) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          grant_nxt = (winner == CC_PORT_I) ? 2'b10 : 2'b01;
          adr_nxt   = (winner == CC_PORT_I) ? bus.adr1_cc2arb : bus.adr0_cc2arb;
        end
      end
      REQ: begin
        if (bus.ack_mem2arb) begin
          cnt_inc = 1'b1;
          if (cnt_done) begin
            state_nxt = DRAIN;
            req_nxt   = 1'b0;
          end else begin
            state_nxt = BURST;
          end
        end
      end
      BURST: begin
        if (bus.ack_mem2arb) begin
          cnt_inc = 1'b1;
          if (cnt_done) begin
            state_nxt = DRAIN;
            req_nxt   = 1'b0;
          end
        end
      end
      DRAIN: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
        rr_nxt    = (grant == 2'b01) ? CC_PORT_I : CC_PORT_D;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pointer and registered memory-side outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr    <= CC_PORT_D;
      grant <= 2'b00;
      adr_q <= '0;
      req_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
      grant <= grant_nxt;
      adr_q <= adr_nxt;
      req_q <= req_nxt;
    end
  end

  // Zero-latency steering: only the owner sees acks, only during a live refill
  always_comb begin
    in_burst        = (state == REQ) || (state == BURST);
    busy            = (state != IDLE);
    bus.req_arb2mem = req_q;
    bus.adr_arb2mem = adr_q;
    bus.ack_arb2cc0 = bus.ack_mem2arb & grant[CC_PORT_D] & in_burst;
    bus.ack_arb2cc1 = bus.ack_mem2arb & grant[CC_PORT_I] & in_burst;
    bus.dat_arb2cc0 = grant[CC_PORT_D] ? bus.dat_mem2arb : {DATA_WIDTH{1'b0}};
    bus.dat_arb2cc1 = grant[CC_PORT_I] ? bus.dat_mem2arb : {DATA_WIDTH{1'b0}};
  end

endmodule
